// File: rtl/mask_index_encoder.sv
`default_nettype none
// ============================================================================
// Module      : mask_index_encoder
// Description : Sequential multi-hot mask to index encoder. Scans one set bit
//               per cycle (lowest index first) and emits the indices packed
//               K per beat over a valid/ready handshake, with out_last on the
//               final beat of each mask.
// Revision    : 1.0 - initial release
// ============================================================================
module mask_index_encoder #(
    parameter int SIZE  = 8,
    parameter int K     = 4,
    parameter int BIT   = $clog2(SIZE),
    parameter int CNT_W = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [SIZE-1:0]    in_mask,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [K*BIT-1:0]   out_addr,
    output logic [CNT_W-1:0]   out_count,
    output logic [K-1:0]       out_lane_valid,
    output logic               out_last
);

    localparam logic [1:0]       S_IDLE = 2'd0;
    localparam logic [1:0]       S_SCAN = 2'd1;
    localparam logic [1:0]       S_EMIT = 2'd2;
    localparam logic [CNT_W-1:0] c_K    = CNT_W'(K);

    logic [1:0]       r_state;
    logic [SIZE-1:0]  r_work;
    logic [K*BIT-1:0] r_slots;
    logic [CNT_W-1:0] r_cnt;

    logic [BIT-1:0]   w_low;
    logic [SIZE-1:0]  w_work_clr;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [K-1:0]     w_lane;
    logic             w_emit;

    // Priority encoder: lowest set index of the remaining work mask.
    always_comb begin
        w_low = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (r_work[i]) w_low = BIT'(i);
        end
    end

    assign w_work_clr = r_work & ~(SIZE'(1) << w_low);
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_emit     = (r_state == S_EMIT);

    // Thermometer of occupied slots, only meaningful while a beat is presented.
    always_comb begin
        w_lane = '0;
        for (int g = 0; g < K; g++) begin
            w_lane[g] = w_emit && (CNT_W'(g) < r_cnt);
        end
    end

    // Outputs are pure decodes of registered state; slots outside EMIT read 0.
    assign in_ready       = (r_state == S_IDLE);
    assign out_valid      = w_emit;
    assign out_addr       = w_emit ? r_slots : '0;
    assign out_count      = w_emit ? r_cnt : '0;
    assign out_lane_valid = w_lane;
    assign out_last       = w_emit && (r_work == '0);

    // Control FSM: accept a mask, scan one bit per cycle, present beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_slots <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work  <= in_mask;
                        r_slots <= '0;
                        r_cnt   <= '0;
                        r_state <= (in_mask == '0) ? S_EMIT : S_SCAN;
                    end
                end
                S_SCAN: begin
                    for (int g = 0; g < K; g++) begin
                        if (r_cnt == CNT_W'(g)) r_slots[g*BIT +: BIT] <= w_low;
                    end
                    r_work <= w_work_clr;
                    r_cnt  <= w_cnt_inc;
                    if ((w_cnt_inc == c_K) || (w_work_clr == '0)) begin
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (r_work == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_slots <= '0;
                            r_cnt   <= '0;
                            r_state <= S_SCAN;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mask_index_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mask_index_encoder
// Description : Self-checking bench for mask_index_encoder (SIZE=8, K=4):
//               table of beats plus hand-written stall, reset and
//               back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_index_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_mask;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_addr;
    logic [2:0]  out_count;
    logic [3:0]  out_lane_valid;
    logic        out_last;

    int n_pass;
    int n_total;

    mask_index_encoder #(.SIZE(8), .K(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_mask        (in_mask),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr),
        .out_count      (out_count),
        .out_lane_valid (out_lane_valid),
        .out_last       (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mask;
        logic        first;
        int          lat;
        logic [11:0] addr;
        logic [2:0]  cnt;
        logic [3:0]  lane;
        logic        last;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid; lat is cycles since the previous edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic send(input logic [7:0] m);
        in_valid = 1'b1;
        in_mask  = m;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mask   = 8'h00;
        out_ready = 1'b0;

        //            mask   first lat addr    cnt   lane    last
        tbl[0] = '{8'h24, 1'b1, 2, 12'h02A, 3'd2, 4'b0011, 1'b1};
        tbl[1] = '{8'hFF, 1'b1, 4, 12'h688, 3'd4, 4'b1111, 1'b0};
        tbl[2] = '{8'hFF, 1'b0, 4, 12'hFAC, 3'd4, 4'b1111, 1'b1};
        tbl[3] = '{8'h00, 1'b1, 1, 12'h000, 3'd0, 4'b0000, 1'b1};
        tbl[4] = '{8'h1F, 1'b1, 4, 12'h688, 3'd4, 4'b1111, 1'b0};
        tbl[5] = '{8'h1F, 1'b0, 1, 12'h004, 3'd1, 4'b0001, 1'b1};
        tbl[6] = '{8'h80, 1'b1, 1, 12'h007, 3'd1, 4'b0001, 1'b1};
        tbl[7] = '{8'h0F, 1'b1, 4, 12'h688, 3'd4, 4'b1111, 1'b1};

        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready",  {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_addr",  {20'd0, out_addr}, 32'd0);
        check("reset out_count", {29'd0, out_count}, 32'd0);
        check("reset lane",      {28'd0, out_lane_valid}, 32'd0);
        check("reset out_last",  {31'd0, out_last}, 32'd0);

        // Table-driven beats
        for (int v = 0; v < 8; v++) begin
            if (tbl[v].first) begin
                check($sformatf("vec%0d in_ready", v), {31'd0, in_ready}, 32'd1);
                send(tbl[v].mask);
                check($sformatf("vec%0d busy", v), {31'd0, in_ready}, 32'd0);
            end
            wait_valid(lat);
            check($sformatf("vec%0d latency", v), lat, tbl[v].lat);
            check($sformatf("vec%0d addr", v),  {20'd0, out_addr}, {20'd0, tbl[v].addr});
            check($sformatf("vec%0d count", v), {29'd0, out_count}, {29'd0, tbl[v].cnt});
            check($sformatf("vec%0d lane", v),  {28'd0, out_lane_valid}, {28'd0, tbl[v].lane});
            check($sformatf("vec%0d last", v),  {31'd0, out_last}, {31'd0, tbl[v].last});
            handshake();
            check($sformatf("vec%0d post valid", v), {31'd0, out_valid}, 32'd0);
            check($sformatf("vec%0d post in_ready", v), {31'd0, in_ready}, {31'd0, tbl[v].last});
        end

        // Stall: 0x81 held with out_ready=0 for 5 cycles; stray in_valid ignored
        send(8'h81);
        wait_valid(lat);
        check("stall latency", lat, 2);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall addr c%0d", c), {20'd0, out_addr}, 32'h038);
            check($sformatf("stall count c%0d", c), {29'd0, out_count}, 32'd2);
            check($sformatf("stall valid c%0d", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall in_ready c%0d", c), {31'd0, in_ready}, 32'd0);
            in_valid = (c == 2);
            in_mask  = 8'hFF;
            tick();
        end
        in_valid = 1'b0;
        check("stall final addr", {20'd0, out_addr}, 32'h038);
        check("stall final last", {31'd0, out_last}, 32'd1);
        handshake();
        check("stall idle in_ready", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 6; c++) tick();
        check("stall no ghost beat", {31'd0, out_valid}, 32'd0);

        // Reset on the second SCAN cycle of 0xF0
        send(8'hF0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst in_ready",  {31'd0, in_ready}, 32'd1);
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst out_addr",  {20'd0, out_addr}, 32'd0);
        check("midrst out_count", {29'd0, out_count}, 32'd0);
        check("midrst lane",      {28'd0, out_lane_valid}, 32'd0);
        check("midrst out_last",  {31'd0, out_last}, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (out_valid) seen++;
            end
            check("midrst no beat", seen, 0);
        end

        // Back-to-back with in_valid held high
        in_valid = 1'b1;
        in_mask  = 8'h03;
        tick();
        in_mask  = 8'h10;
        check("b2b busy", {31'd0, in_ready}, 32'd0);
        wait_valid(lat);
        check("b2b1 latency", lat, 2);
        check("b2b1 addr", {20'd0, out_addr}, 32'h008);
        check("b2b1 lane", {28'd0, out_lane_valid}, 32'h3);
        check("b2b1 last", {31'd0, out_last}, 32'd1);
        handshake();
        check("b2b idle in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b second accepted", {31'd0, in_ready}, 32'd0);
        wait_valid(lat);
        check("b2b2 latency", lat, 1);
        check("b2b2 addr",  {20'd0, out_addr}, 32'h004);
        check("b2b2 count", {29'd0, out_count}, 32'd1);
        check("b2b2 lane",  {28'd0, out_lane_valid}, 32'h1);
        check("b2b2 last",  {31'd0, out_last}, 32'd1);
        handshake();
        check("b2b end in_ready", {31'd0, in_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
